// File: rtl/mc_wb_post_buf.sv
// Write-posting Wishbone front end for the memory controller slave port.
// Writes are acked on FIFO entry and drained in order; reads wait for an empty FIFO.
module mc_wb_post_buf #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   s_wb_addr_i,
  input  logic [31:0]   s_wb_data_i,
  input  logic [3:0]    s_wb_sel_i,
  input  logic          s_wb_we_i,
  input  logic          s_wb_cyc_i,
  input  logic          s_wb_stb_i,
  output logic [31:0]   s_wb_data_o,
  output logic          s_wb_ack_o,
  output logic          s_wb_err_o,
  output logic [31:0]   m_wb_addr_o,
  output logic [31:0]   m_wb_data_o,
  output logic [3:0]    m_wb_sel_o,
  output logic          m_wb_we_o,
  output logic          m_wb_cyc_o,
  output logic          m_wb_stb_o,
  input  logic [31:0]   m_wb_data_i,
  input  logic          m_wb_ack_i,
  input  logic          m_wb_err_i,
  output logic          post_err_o,
  output logic [31:0]   post_err_adr_o,
  input  logic          post_err_clr_i,
  output logic [LW-1:0] fifo_level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd2, S_GAP = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wreq_t;

  wreq_t         mem [DEPTH];
  wreq_t         head;
  logic [1:0]    state;
  logic [LW-1:0] wr_cnt, rd_cnt, level;
  logic          full, push, pop, rd_req, m_done, rd_fin, werr, rd_live;

  assign level        = wr_cnt - rd_cnt;
  assign full         = (level == LW'(DEPTH));
  assign push         = s_wb_cyc_i & s_wb_stb_i & s_wb_we_i & ~full & ~s_wb_ack_o;
  assign rd_req       = s_wb_cyc_i & s_wb_stb_i & ~s_wb_we_i & ~s_wb_ack_o & ~s_wb_err_o;
  assign m_done       = m_wb_ack_i | m_wb_err_i;
  assign pop          = (state == S_WR) & m_done;
  assign werr         = (state == S_WR) & m_wb_err_i;
  // Read result only goes upstream if the requesting cycle never dropped.
  assign rd_fin       = (state == S_RD) & m_done & rd_live & s_wb_cyc_i;
  assign head         = mem[rd_cnt[AW-1:0]];
  assign fifo_level_o = level;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_cnt[AW-1:0]] <= '{addr: s_wb_addr_i, data: s_wb_data_i, sel: s_wb_sel_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      rd_live        <= 1'b0;
      s_wb_data_o    <= '0;
      s_wb_ack_o     <= 1'b0;
      s_wb_err_o     <= 1'b0;
      m_wb_addr_o    <= '0;
      m_wb_data_o    <= '0;
      m_wb_sel_o     <= '0;
      m_wb_we_o      <= 1'b0;
      m_wb_cyc_o     <= 1'b0;
      m_wb_stb_o     <= 1'b0;
      post_err_o     <= 1'b0;
      post_err_adr_o <= '0;
    end else begin
      s_wb_ack_o <= push | (rd_fin & m_wb_ack_i);
      s_wb_err_o <= rd_fin & ~m_wb_ack_i & m_wb_err_i;
      if (rd_fin) s_wb_data_o <= m_wb_data_i;
      if (push) wr_cnt <= wr_cnt + LW'(1);
      if (pop)  rd_cnt <= rd_cnt + LW'(1);

      case (state)
        S_IDLE: begin
          if (level != '0) begin
            state       <= S_WR;
            m_wb_cyc_o  <= 1'b1;
            m_wb_stb_o  <= 1'b1;
            m_wb_we_o   <= 1'b1;
            m_wb_addr_o <= head.addr;
            m_wb_data_o <= head.data;
            m_wb_sel_o  <= head.sel;
          end else if (rd_req) begin
            state       <= S_RD;
            rd_live     <= 1'b1;
            m_wb_cyc_o  <= 1'b1;
            m_wb_stb_o  <= 1'b1;
            m_wb_we_o   <= 1'b0;
            m_wb_addr_o <= s_wb_addr_i;
            m_wb_data_o <= s_wb_data_i;
            m_wb_sel_o  <= s_wb_sel_i;
          end
        end
        S_WR, S_RD: begin
          if (!s_wb_cyc_i) rd_live <= 1'b0;
          if (m_done) begin
            state      <= S_GAP;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // A new error beats a same-cycle clear and re-arms address capture.
      if (werr) begin
        post_err_o <= 1'b1;
        if (!post_err_o || post_err_clr_i) post_err_adr_o <= m_wb_addr_o;
      end else if (post_err_clr_i) begin
        post_err_o     <= 1'b0;
        post_err_adr_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mc_wb_post_buf.sv
// Bench for mc_wb_post_buf: directed scenarios plus random traffic against a
// program-order memory model and a logged downstream transaction stream.
module tb_mc_wb_post_buf;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] s_wb_addr_i = '0, s_wb_data_i = '0;
  logic [3:0]  s_wb_sel_i = '0;
  logic        s_wb_we_i = 1'b0, s_wb_cyc_i = 1'b0, s_wb_stb_i = 1'b0;
  logic [31:0] s_wb_data_o;
  logic        s_wb_ack_o, s_wb_err_o;
  logic [31:0] m_wb_addr_o, m_wb_data_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
  logic [31:0] m_wb_data_i = '0;
  logic        m_wb_ack_i = 1'b0, m_wb_err_i = 1'b0;
  logic        post_err_o;
  logic [31:0] post_err_adr_o;
  logic        post_err_clr_i;
  logic [2:0]  fifo_level_o;

  int checks = 0, failures = 0, cycle = 0;
  int ack_delay = 0;
  bit hold_ack = 1'b0, clr_req = 1'b0, clr_with_err = 1'b0;
  int last_wr_ack_cyc = 0, last_rd_start_cyc = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } txn_t;

  txn_t        obs_q[$], exp_q[$];
  logic [31:0] ctl_mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  bit          err_set [logic [31:0]];

  assign post_err_clr_i = clr_req | (clr_with_err & m_wb_err_i);

  mc_wb_post_buf #(.DEPTH(4), .LW(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_wb_addr_i(s_wb_addr_i), .s_wb_data_i(s_wb_data_i), .s_wb_sel_i(s_wb_sel_i),
    .s_wb_we_i(s_wb_we_i), .s_wb_cyc_i(s_wb_cyc_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_data_o(s_wb_data_o), .s_wb_ack_o(s_wb_ack_o), .s_wb_err_o(s_wb_err_o),
    .m_wb_addr_o(m_wb_addr_o), .m_wb_data_o(m_wb_data_o), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_data_i(m_wb_data_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
    .post_err_o(post_err_o), .post_err_adr_o(post_err_adr_o),
    .post_err_clr_i(post_err_clr_i), .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle <= cycle + 1;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dflt(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Controller model: responds ack_delay cycles after stb, logs every completed transfer.
  int wait_cnt = 0;
  bit prev_stb = 1'b0;
  always @(negedge clk_i) begin
    txn_t        t;
    logic [31:0] cur;
    m_wb_ack_i  = 1'b0;
    m_wb_err_i  = 1'b0;
    m_wb_data_i = $urandom;
    if (rst_i || !(m_wb_cyc_o && m_wb_stb_o)) begin
      wait_cnt = 0;
      prev_stb = 1'b0;
    end else begin
      if (!prev_stb && !m_wb_we_o) last_rd_start_cyc = cycle;
      prev_stb = 1'b1;
      if (!hold_ack) begin
        if (wait_cnt >= ack_delay) begin
          cur    = ctl_mem.exists(m_wb_addr_o) ? ctl_mem[m_wb_addr_o] : dflt(m_wb_addr_o);
          t.we   = m_wb_we_o;
          t.addr = m_wb_addr_o;
          t.data = m_wb_we_o ? m_wb_data_o : 32'h0;
          t.sel  = m_wb_we_o ? m_wb_sel_o : 4'h0;
          if (err_set.exists(m_wb_addr_o)) m_wb_err_i = 1'b1;
          else begin
            m_wb_ack_i = 1'b1;
            if (m_wb_we_o) ctl_mem[m_wb_addr_o] = merge(cur, m_wb_data_o, m_wb_sel_o);
            else           m_wb_data_i = cur;
          end
          if (m_wb_we_o) last_wr_ack_cyc = cycle;
          obs_q.push_back(t);
          wait_cnt = 0;
        end else wait_cnt++;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wb_write(logic [31:0] a, logic [31:0] d, logic [3:0] s, output int lat);
    txn_t t;
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b1;
    s_wb_addr_i = a; s_wb_data_i = d; s_wb_sel_i = s;
    lat = 0;
    do begin tick(); lat++; end while (!s_wb_ack_o && lat < 200);
    chk("wr_ack", {31'b0, s_wb_ack_o}, 32'd1);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    if (s_wb_ack_o) begin
      t.we = 1'b1; t.addr = a; t.data = d; t.sel = s;
      exp_q.push_back(t);
      exp_mem[a] = merge(exp_mem.exists(a) ? exp_mem[a] : dflt(a), d, s);
    end
  endtask

  task automatic wb_read(logic [31:0] a, output logic [31:0] d, output logic ack,
                         output logic err, output int lat);
    txn_t t;
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b0;
    s_wb_addr_i = a; s_wb_data_i = $urandom; s_wb_sel_i = 4'hF;
    lat = 0;
    do begin tick(); lat++; end while (!s_wb_ack_o && !s_wb_err_o && lat < 200);
    chk("rd_done", {31'b0, s_wb_ack_o | s_wb_err_o}, 32'd1);
    d = s_wb_data_o; ack = s_wb_ack_o; err = s_wb_err_o;
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
    t.we = 1'b0; t.addr = a; t.data = '0; t.sel = '0;
    exp_q.push_back(t);
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_level_o != 0 || m_wb_cyc_o) && n < 300) begin tick(); n++; end
    chk("drain_idle", {31'b0, (fifo_level_o != 0) || m_wb_cyc_o}, 32'd0);
    tick(2);
  endtask

  task automatic compare_logs(string tag);
    chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), obs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s_wesel%0d", tag, i), {27'b0, obs_q[i].we, obs_q[i].sel},
          {27'b0, exp_q[i].we, exp_q[i].sel});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd, ea;
    logic        ack, err;
    bit          seen;

    // Reset state
    tick(3);
    rst_i = 1'b0;
    tick();
    chk("rst_s_ack", {31'b0, s_wb_ack_o}, 0);
    chk("rst_s_err", {31'b0, s_wb_err_o}, 0);
    chk("rst_s_data", s_wb_data_o, 0);
    chk("rst_m_ctl", {29'b0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 0);
    chk("rst_m_addr", m_wb_addr_o, 0);
    chk("rst_m_data", m_wb_data_o, 0);
    chk("rst_post_err", {31'b0, post_err_o}, 0);
    chk("rst_post_adr", post_err_adr_o, 0);
    chk("rst_level", {29'b0, fifo_level_o}, 0);

    // Single posted write
    hold_ack = 1'b1;
    wb_write(32'h100, 32'hDEADBEEF, 4'hF, lat);
    chk("w1_ack_lat", lat, 1);
    tick(2);
    chk("w1_m_ctl", {29'b0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 32'd7);
    chk("w1_m_addr", m_wb_addr_o, 32'h100);
    chk("w1_m_data", m_wb_data_o, 32'hDEADBEEF);
    chk("w1_m_sel", {28'b0, m_wb_sel_o}, 32'hF);
    chk("w1_level1", {29'b0, fifo_level_o}, 1);
    hold_ack = 1'b0;
    tick();
    chk("w1_level0", {29'b0, fifo_level_o}, 0);
    drain();
    compare_logs("w1");

    // Fill to full, fifth write stalls
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) wb_write(32'h1000 + 4*i, 32'h1111_0000 + i, 4'hF, lat);
    tick();
    chk("full_level", {29'b0, fifo_level_o}, 4);
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b1;
    s_wb_addr_i = 32'h1010; s_wb_data_i = 32'h1111_0004; s_wb_sel_i = 4'hF;
    seen = 1'b0;
    repeat (6) begin tick(); if (s_wb_ack_o) seen = 1'b1; end
    chk("full_stall", {31'b0, seen}, 0);
    chk("full_level_hold", {29'b0, fifo_level_o}, 4);
    hold_ack = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!s_wb_ack_o && lat < 100);
    chk("w5_ack", {31'b0, s_wb_ack_o}, 1);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    exp_q.push_back('{we: 1'b1, addr: 32'h1010, data: 32'h1111_0004, sel: 4'hF});
    exp_mem[32'h1010] = 32'h1111_0004;
    drain();
    compare_logs("fill");

    // Read right behind a write to the same address
    ack_delay = 2;
    wb_write(32'h200, 32'hCAFE_0200, 4'hF, lat);
    wb_read(32'h200, rd, ack, err, lat);
    chk("raw_data", rd, 32'hCAFE_0200);
    chk("raw_ack", {30'b0, ack, err}, 32'd2);
    chk("raw_after_gap", {31'b0, last_rd_start_cyc > last_wr_ack_cyc + 1}, 1);
    drain();
    compare_logs("raw");

    // Read latency vs controller delay
    for (int d = 0; d < 4; d += 3) begin
      ack_delay = d;
      wb_read(32'h40, rd, ack, err, lat);
      chk($sformatf("rd_lat_d%0d", d), lat, 2 + d);
      chk($sformatf("rd_data_d%0d", d), rd, dflt(32'h40));
      drain();
    end
    compare_logs("lat");

    // Posted-write errors, then clear colliding with a new error
    ack_delay = 0;
    err_set[32'h300] = 1'b1; err_set[32'h304] = 1'b1; err_set[32'h308] = 1'b1;
    wb_write(32'h300, 32'h3, 4'hF, lat);
    wb_write(32'h304, 32'h4, 4'hF, lat);
    drain();
    chk("perr_flag", {31'b0, post_err_o}, 1);
    chk("perr_adr_first", post_err_adr_o, 32'h300);
    clr_with_err = 1'b1;
    wb_write(32'h308, 32'h8, 4'hF, lat);
    drain();
    clr_with_err = 1'b0;
    chk("perr_clr_err_flag", {31'b0, post_err_o}, 1);
    chk("perr_clr_err_adr", post_err_adr_o, 32'h308);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("perr_cleared", {31'b0, post_err_o}, 0);
    chk("perr_adr_cleared", post_err_adr_o, 0);
    compare_logs("perr");

    // Read with controller error
    err_set[32'h400] = 1'b1;
    wb_read(32'h400, rd, ack, err, lat);
    chk("rerr_flags", {30'b0, ack, err}, 32'd1);
    tick();
    chk("rerr_pulse", {30'b0, s_wb_ack_o, s_wb_err_o}, 0);
    chk("rerr_no_post", {31'b0, post_err_o}, 0);
    drain();
    compare_logs("rerr");

    // Random traffic against the program-order memory model
    for (int i = 0; i < 80; i++) begin
      ack_delay = $urandom_range(0, 3);
      ea = 32'h800 + 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 6)
        wb_write(ea, $urandom, 4'($urandom_range(1, 15)), lat);
      else begin
        wb_read(ea, rd, ack, err, lat);
        chk($sformatf("rnd_rd%0d", i), rd, exp_mem.exists(ea) ? exp_mem[ea] : dflt(ea));
      end
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end
    drain();
    compare_logs("rnd");

    // Read abandoned while waiting behind a write
    ack_delay = 0;
    hold_ack = 1'b1;
    wb_write(32'h500, 32'h5, 4'hF, lat);
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b0; s_wb_addr_i = 32'h504;
    tick(3);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
    hold_ack = 1'b0;
    seen = 1'b0;
    repeat (10) begin tick(); if (s_wb_ack_o || s_wb_err_o) seen = 1'b1; end
    chk("abandon_wait_noack", {31'b0, seen}, 0);
    drain();
    compare_logs("abw");

    // Read abandoned after issue completes downstream silently
    hold_ack = 1'b1;
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b0; s_wb_addr_i = 32'h508;
    tick(3);
    chk("abandon_rd_issued", {29'b0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 32'd6);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
    hold_ack = 1'b0;
    seen = 1'b0;
    repeat (10) begin tick(); if (s_wb_ack_o || s_wb_err_o) seen = 1'b1; end
    chk("abandon_rd_noack", {31'b0, seen}, 0);
    exp_q.push_back('{we: 1'b0, addr: 32'h508, data: 32'h0, sel: 4'h0});
    drain();
    compare_logs("abr");

    // Reset while a write is active with three queued
    hold_ack = 1'b1;
    for (int i = 0; i < 3; i++) wb_write(32'h600 + 4*i, 32'h6000 + i, 4'hF, lat);
    tick();
    chk("mid_level3", {29'b0, fifo_level_o}, 3);
    chk("mid_cyc", {31'b0, m_wb_cyc_o}, 1);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_ctl", {29'b0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 0);
    chk("mid_rst_level", {29'b0, fifo_level_o}, 0);
    chk("mid_rst_addr", m_wb_addr_o, 0);
    chk("mid_rst_sack", {30'b0, s_wb_ack_o, s_wb_err_o}, 0);
    rst_i = 1'b0;
    hold_ack = 1'b0;
    tick(6);
    chk("mid_lost_cyc", {31'b0, m_wb_cyc_o}, 0);
    chk("mid_lost_obs", obs_q.size(), 0);
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
